// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-mode
// encodings and small helpers that decode which directions are enabled.
package edge_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t MODE_NONE = 2'b00;
    localparam edge_mode_t MODE_RISE = 2'b01;
    localparam edge_mode_t MODE_FALL = 2'b10;
    localparam edge_mode_t MODE_BOTH = 2'b11;

    function automatic logic mode_rise_en(input edge_mode_t m);
        return (m == MODE_RISE) || (m == MODE_BOTH);
    endfunction

    function automatic logic mode_fall_en(input edge_mode_t m);
        return (m == MODE_FALL) || (m == MODE_BOTH);
    endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// Bundle of the detector's data/control signals. The master side drives the
// raw inputs and controls; the slave side (the detector) returns the
// filtered levels, ticks and counters.
interface multi_edge_detector_if #(
    parameter int N_CH    = 4,
    parameter int COUNT_W = 8
);
    import edge_pkg::*;

    logic [N_CH-1:0]         signal_in;
    edge_mode_t              mode;
    logic                    count_clr;
    logic [N_CH-1:0]         level;
    logic [N_CH-1:0]         rise_tick;
    logic [N_CH-1:0]         fall_tick;
    logic [N_CH-1:0]         edge_tick;
    logic [N_CH-1:0]         glitch_tick;
    logic [N_CH*COUNT_W-1:0] edge_count;

    modport master (
        output signal_in, mode, count_clr,
        input  level, rise_tick, fall_tick, edge_tick, glitch_tick, edge_count
    );

    modport slave (
        input  signal_in, mode, count_clr,
        output level, rise_tick, fall_tick, edge_tick, glitch_tick, edge_count
    );

endinterface

// File: rtl/edge_filter_ch.sv
// One detector channel: synchroniser chain, stable-count debounce filter,
// mode-gated registered ticks and a saturating edge counter.
module edge_filter_ch
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int COUNT_W       = 8,
    parameter bit INIT_LEVEL    = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sig,
    input  edge_mode_t         mode,
    input  logic               count_clr,
    output logic               level,
    output logic               rise_tick,
    output logic               fall_tick,
    output logic               edge_tick,
    output logic               glitch_tick,
    output logic [COUNT_W-1:0] edge_count
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] EC_MAX   = '1;

    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             rise_en;
    logic             fall_en;

    assign rise_en = mode_rise_en(mode);
    assign fall_en = mode_fall_en(mode);

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = sig;
        end else begin : g_sync
            // Bit 0 is the first stage; the oldest sample leaves at the top.
            logic [SYNC_STAGES-1:0] sync_q;

            // Shift the raw input through the synchroniser chain.
            always_ff @(posedge clk) begin
                if (reset) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
                else       sync_q <= (sync_q << 1) | SYNC_STAGES'(sig);
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Debounce: a differing sample must persist STABLE_CYCLES edges to flip level.
    always_ff @(posedge clk) begin
        if (reset) begin
            level       <= INIT_LEVEL;
            cnt         <= '0;
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
            edge_tick   <= 1'b0;
            glitch_tick <= 1'b0;
        end else begin
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
            edge_tick   <= 1'b0;
            glitch_tick <= 1'b0;
            if (s == level) begin
                // A non-zero count means a change was pending and just aborted.
                cnt         <= '0;
                glitch_tick <= (cnt != '0);
            end else if (cnt == CNT_LAST) begin
                level     <= s;
                cnt       <= '0;
                rise_tick <= s & rise_en;
                fall_tick <= ~s & fall_en;
                edge_tick <= s ? rise_en : fall_en;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Count qualified ticks one cycle after they appear; clear wins, saturate at max.
    always_ff @(posedge clk) begin
        if (reset || count_clr)                     edge_count <= '0;
        else if (edge_tick && (edge_count != EC_MAX)) edge_count <= edge_count + 1'b1;
    end

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector top: one edge_filter_ch per input bit, outputs
// concatenated onto the interface buses.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int COUNT_W       = 8,
    parameter bit INIT_LEVEL    = 1'b0
) (
    input logic                  clk,
    input logic                  reset,
    multi_edge_detector_if.slave bus
);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            edge_filter_ch #(
                .SYNC_STAGES  (SYNC_STAGES),
                .STABLE_CYCLES(STABLE_CYCLES),
                .COUNT_W      (COUNT_W),
                .INIT_LEVEL   (INIT_LEVEL)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .sig        (bus.signal_in[i]),
                .mode       (bus.mode),
                .count_clr  (bus.count_clr),
                .level      (bus.level[i]),
                .rise_tick  (bus.rise_tick[i]),
                .fall_tick  (bus.fall_tick[i]),
                .edge_tick  (bus.edge_tick[i]),
                .glitch_tick(bus.glitch_tick[i]),
                .edge_count (bus.edge_count[i*COUNT_W +: COUNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed scenarios plus random traffic,
// every cycle compared against a sample-history reference model.
module tb_multi_edge_detector;
    import edge_pkg::*;

    localparam int NC = 4;
    localparam int SS = 2;
    localparam int SC = 4;
    localparam int CW = 2;
    localparam bit IL = 1'b0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_edge_detector_if #(.N_CH(NC), .COUNT_W(CW)) bus();

    multi_edge_detector #(
        .N_CH(NC), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .COUNT_W(CW), .INIT_LEVEL(IL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // s is the input captured SS edges earlier; level flips once the last SC
    // samples of s (since reset) all differ from it; a glitch is a sample back
    // at level right after one that differed without a flip.
    logic [NC-1:0] pipe_m[$];
    bit            sh[NC][$];
    logic [NC-1:0] lvl_m, rise_m, fall_m, glit_m;
    int            cnt_m[NC];
    bit            started = 1'b0;

    task automatic model_step();
        logic [NC-1:0] s_v;
        logic [NC-1:0] r_n, f_n, g_n;
        int  n;
        bit  all_diff;
        if (reset) begin
            pipe_m.delete();
            repeat (SS) pipe_m.push_back({NC{IL}});
            for (int c = 0; c < NC; c++) begin
                sh[c].delete();
                cnt_m[c] = 0;
            end
            lvl_m = {NC{IL}}; rise_m = '0; fall_m = '0; glit_m = '0;
            started = 1'b1;
            return;
        end
        if (!started) return;
        s_v = pipe_m.pop_front();
        pipe_m.push_back(bus.signal_in);
        r_n = '0; f_n = '0; g_n = '0;
        for (int c = 0; c < NC; c++) begin
            if (bus.count_clr) cnt_m[c] = 0;
            else if ((rise_m[c] | fall_m[c]) && cnt_m[c] < (1 << CW) - 1) cnt_m[c]++;
            sh[c].push_back(s_v[c]);
            if (sh[c].size() > SC) void'(sh[c].pop_front());
            n = sh[c].size();
            all_diff = (n == SC);
            for (int j = 0; j < n; j++) if (sh[c][j] == lvl_m[c]) all_diff = 1'b0;
            g_n[c] = (s_v[c] == lvl_m[c]) && (n >= 2) && (sh[c][n-2] != lvl_m[c]);
            if (all_diff) begin
                lvl_m[c] = s_v[c];
                r_n[c] = s_v[c] & bus.mode[0];
                f_n[c] = ~s_v[c] & bus.mode[1];
            end
        end
        rise_m = r_n; fall_m = f_n; glit_m = g_n;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle comparison ----------------
    int tot_rise[NC], tot_fall[NC], tot_glit[NC];
    initial begin
        for (int c = 0; c < NC; c++) begin
            tot_rise[c] = 0; tot_fall[c] = 0; tot_glit[c] = 0;
        end
        forever begin
            @(negedge clk);
            if (started) begin
                logic [NC*CW-1:0] ec_exp;
                for (int c = 0; c < NC; c++) ec_exp[c*CW +: CW] = CW'(cnt_m[c]);
                chk("level",  32'(bus.level),       32'(lvl_m));
                chk("rise",   32'(bus.rise_tick),   32'(rise_m));
                chk("fall",   32'(bus.fall_tick),   32'(fall_m));
                chk("edge",   32'(bus.edge_tick),   32'(rise_m | fall_m));
                chk("glitch", 32'(bus.glitch_tick), 32'(glit_m));
                chk("count",  32'(bus.edge_count),  32'(ec_exp));
                for (int c = 0; c < NC; c++) begin
                    tot_rise[c] += int'(bus.rise_tick[c]);
                    tot_fall[c] += int'(bus.fall_tick[c]);
                    tot_glit[c] += int'(bus.glitch_tick[c]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        bus.count_clr = 1'b1;
        step(1);
        bus.count_clr = 1'b0;
    endtask

    initial begin
        int r0, f0, g0;
        bit seen;
        reset = 1'b1;
        bus.signal_in = '1;
        bus.mode = MODE_BOTH;
        bus.count_clr = 1'b0;

        // Reset defaults and release with inputs away from INIT_LEVEL.
        step(3);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_rise",  32'(bus.rise_tick), 0);
        chk("rst_count", 32'(bus.edge_count), 0);
        reset = 1'b0;
        step(5);
        chk("rel_rise_early", 32'(bus.rise_tick), 0);
        step(1);
        chk("rel_rise", 32'(bus.rise_tick), 32'hF);
        step(1);
        for (int c = 0; c < NC; c++) chk("rel_count", 32'(bus.edge_count[c*CW +: CW]), 1);

        bus.signal_in = '0;
        step(12);
        clr_counts();

        // Clean rise/fall on ch0.
        r0 = tot_rise[0]; f0 = tot_fall[0];
        bus.signal_in[0] = 1'b1;
        step(5);
        chk("clean_rise_early", 32'(bus.rise_tick[0]), 0);
        step(1);
        chk("clean_rise_at", 32'(bus.rise_tick[0]), 1);
        step(4);
        bus.signal_in[0] = 1'b0;
        step(6);
        chk("clean_fall_at", 32'(bus.fall_tick[0]), 1);
        step(6);
        chk("clean_nrise", 32'(tot_rise[0] - r0), 1);
        chk("clean_nfall", 32'(tot_fall[0] - f0), 1);
        chk("clean_count", 32'(bus.edge_count[0 +: CW]), 2);

        // 2-cycle glitch on ch1.
        r0 = tot_rise[1]; g0 = tot_glit[1];
        bus.signal_in[1] = 1'b1;
        step(2);
        bus.signal_in[1] = 1'b0;
        step(8);
        chk("glitch_nrise", 32'(tot_rise[1] - r0), 0);
        chk("glitch_n",     32'(tot_glit[1] - g0), 1);
        chk("glitch_level", 32'(bus.level[1]), 0);

        // Rising-only mode on ch2.
        bus.mode = MODE_RISE;
        clr_counts();
        r0 = tot_rise[2]; f0 = tot_fall[2];
        for (int t = 0; t < 3; t++) begin
            bus.signal_in[2] = ~bus.signal_in[2];
            step(8);
            chk("mode_level", 32'(bus.level[2]), (t % 2 == 0) ? 1 : 0);
        end
        step(2);
        chk("mode_nrise", 32'(tot_rise[2] - r0), 2);
        chk("mode_nfall", 32'(tot_fall[2] - f0), 0);
        chk("mode_count", 32'(bus.edge_count[2*CW +: CW]), 2);

        // Saturation on ch3 and ch0.
        bus.mode = MODE_BOTH;
        clr_counts();
        for (int t = 0; t < 5; t++) begin
            bus.signal_in[3] = ~bus.signal_in[3];
            bus.signal_in[0] = ~bus.signal_in[0];
            step(8);
        end
        step(2);
        chk("sat_count3", 32'(bus.edge_count[3*CW +: CW]), 3);
        chk("sat_count0", 32'(bus.edge_count[0 +: CW]), 3);

        // count_clr in the same cycle as a tick.
        bus.signal_in[0] = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (bus.edge_tick[0] === 1'b1) begin
                seen = 1'b1;
                bus.count_clr = 1'b1;
            end
        end
        chk("clr_tick_seen", 32'(seen), 1);
        @(posedge clk); #1;
        bus.count_clr = 1'b0;
        @(negedge clk);
        chk("clr_prio", 32'(bus.edge_count[0 +: CW]), 0);
        step(4);

        // Reset two cycles into a pending change on ch1.
        bus.signal_in[1] = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rp_level", 32'(bus.level[1]), 0);
        step(5);
        chk("rp_rise_early", 32'(bus.rise_tick[1]), 0);
        chk("rp_level_hold", 32'(bus.level[1]), 0);
        step(1);
        chk("rp_rise_at", 32'(bus.rise_tick[1]), 1);
        step(4);

        // Random traffic.
        for (int it = 0; it < 400; it++) begin
            bus.signal_in = NC'($urandom);
            if ($urandom_range(0, 7) == 0) bus.mode = edge_mode_t'($urandom_range(0, 3));
            bus.count_clr = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 63) == 0);
            step(1);
            bus.count_clr = 1'b0;
            reset = 1'b0;
            step($urandom_range(0, 7));
        end
        step(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised N-channel edge detector, successor to the lab's single-bit rising-edge tick generator. Each channel synchronises an asynchronous input, debounces it with a stable-count filter, and emits one-cycle rise/fall/any-edge ticks qualified by a runtime mode. Each channel also keeps a saturating edge counter and flags aborted transitions (glitches). It sits between raw pin/button inputs and the lab's control FSMs.

## Interface
- `N_CH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (0..3; 0 = input used directly).
- `STABLE_CYCLES`, 4: consecutive cycles a changed input must hold before the filtered level flips (≥1; 1 = no filtering).
- `COUNT_W`, 8: width of each per-channel edge counter.
- `INIT_LEVEL`, 0: filtered level and synchroniser value after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `signal_in`  in  N_CH  raw, possibly asynchronous inputs.
- `mode`  in  2  00 none, 01 rising, 10 falling, 11 both.
- `count_clr`  in  1  synchronous clear of all edge counters.
- `level`  out  N_CH  filtered level per channel.
- `rise_tick`  out  N_CH  one-cycle pulse on a filtered 0→1 transition, gated by mode.
- `fall_tick`  out  N_CH  one-cycle pulse on a filtered 1→0 transition, gated by mode.
- `edge_tick`  out  N_CH  OR of `rise_tick` and `fall_tick` per channel.
- `glitch_tick`  out  N_CH  one-cycle pulse when a pending change aborts.
- `edge_count`  out  N_CH*COUNT_W  flat bus; channel i occupies bits [i*COUNT_W +: COUNT_W].

## Operation
- Reset values: `level` and synchroniser flops = INIT_LEVEL; all ticks = 0; `edge_count` = 0; filter counters = 0.
- Synchroniser: a shift chain of SYNC_STAGES flops. `s` is the last stage, or `signal_in` when SYNC_STAGES = 0.
- Per-channel filter, two states: STABLE (`cnt` = 0) and PENDING (`cnt` > 0). Each edge applies one of these cases:
  - If `s == level`: `cnt` goes to 0. If the channel was PENDING, `glitch_tick` pulses.
  - If `s != level` and `cnt == STABLE_CYCLES-1`: `level` takes `s`, `cnt` goes to 0, and an edge event fires.
  - Otherwise: `cnt` increments.
- `cnt` width is max(1, $clog2(STABLE_CYCLES)).
- An edge event asserts `rise_tick` or `fall_tick` only if `mode` (sampled at that edge) enables that direction. The filter and `level` ignore `mode`.
- All ticks are registered and last exactly one cycle. Back-to-back ticks are impossible when STABLE_CYCLES > 1.
- `edge_count[i]` increments on each qualified tick and saturates at 2^COUNT_W−1.
  - `count_clr` has priority over a simultaneous increment: the result is 0.
- `reset` mid-PENDING discards the pending change. No tick is produced for it.
- Inputs that differ from INIT_LEVEL at reset release produce a normal edge after the full latency.

## Timing
- Let edge k be the first clock edge at which the first synchroniser stage, or `s` when SYNC_STAGES = 0, captures a new value.
- `level` flips and the tick is registered at edge k + SYNC_STAGES + STABLE_CYCLES − 1. The tick is visible for the following cycle.
- Minimum input pulse that is guaranteed to propagate: STABLE_CYCLES cycles.
- Shorter pulses produce `glitch_tick` at the edge after `s` returns, provided at least one PENDING cycle occurred.
- `edge_count` updates at the edge following the tick, i.e. it lags `edge_tick` by one cycle.
- `mode` changes take effect at the next edge event. Ticks already registered are not cancelled.

## Structure
- Package `edge_pkg`: mode encodings `MODE_NONE`, `MODE_RISE`, `MODE_FALL`, `MODE_BOTH`, and the 2-bit `edge_mode_t` typedef.
- Sub-module `edge_filter_ch`: one channel's synchroniser, filter, tick gating and saturating counter. The top generates N_CH instances and concatenates the outputs.

## Test plan
- **Reset defaults.** Assert `reset` with `signal_in` = 4'hF and INIT_LEVEL = 0. Required: all outputs 0 during reset. After release, `rise_tick` = 4'hF exactly at release + 2 + 4 − 1 edges, and `edge_count` of every channel = 1.
- **Clean rise/fall, mode = 11.** Drive ch0 high for 10 cycles, then low. Required: one `rise_tick[0]`, one `fall_tick[0]`, each 5 edges after the corresponding input change; `edge_count[0]` = 2.
- **Glitch rejection.** Apply a 2-cycle high pulse on ch1 with STABLE_CYCLES = 4. Required: no `rise_tick`, one `glitch_tick[1]`, `level[1]` stays 0.
- **Mode gating.** Set `mode` = 01 and toggle ch2 three times. Required: 2 `rise_tick`, 0 `fall_tick`, `level[2]` toggles on every edge, `edge_count[2]` = 2.
- **Counter boundaries.**
  - With COUNT_W = 2 and 5 qualified edges, `edge_count` saturates at 3.
  - `count_clr` asserted in the same cycle as a tick yields 0.
- **Reset mid-PENDING.** Assert `reset` 2 cycles into a pending change. Required: no tick, `level` = INIT_LEVEL, and the filter counter restarts from 0.
